// File: rtl/lut_ram_pkg.sv
// -----------------------------------------------------------------------------
// lut_ram_pkg
//   Shared types for the LUT RAM controller and its neighbours.
//   - lut_ctrl_state_e : controller FSM states
//   - lut_addr_t / lut_data_t   : 256 x 32 LUT configuration
//   - lut8_addr_t / lut8_data_t : 8 x 32 LUT configuration
// -----------------------------------------------------------------------------
package lut_ram_pkg;

  typedef enum logic [1:0] {
    RST  = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } lut_ctrl_state_e;

  // 256-entry x 32-bit LUT
  typedef logic [7:0]  lut_addr_t;
  typedef logic [31:0] lut_data_t;

  // 8-entry x 32-bit LUT
  typedef logic [2:0]  lut8_addr_t;
  typedef logic [31:0] lut8_data_t;

endpackage

// File: rtl/lut_ram_ctrl.sv
// -----------------------------------------------------------------------------
// lut_ram_ctrl
//   Master-side controller for a LUT RAM with a synchronous write port and a
//   combinational read port. After reset (or on clear_req) it sweeps every
//   entry to INIT_VALUE, then serves single-word read/write requests from a
//   valid/ready port. Read data comes back through a one-entry valid/ready
//   response register with one clock of latency.
//
//   State table:
//     RST  | one clock after reset release; outputs idle
//     INIT | sweep: write INIT_VALUE to address cnt, one entry per clock
//     RUN  | serve requests; clear_req returns to INIT
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   clear_req                       re-run the init sweep (RUN only)
//   init_done                       high while in RUN
//   req_valid/req_ready             request handshake
//   req_we/req_addr/req_wdata       request payload (write=1)
//   resp_valid/resp_ready           response handshake
//   resp_rdata                      read data
//   lut_wr_en/lut_wr_addr/lut_wr_data  LUT RAM write port
//   lut_rd_addr/lut_rd_data         LUT RAM read port (combinational read)
// -----------------------------------------------------------------------------
module lut_ram_ctrl
  import lut_ram_pkg::*;
#(
  parameter int unsigned LUT_WIDTH = 32,
  parameter int unsigned LUT_DEPTH = 256,
  parameter logic [LUT_WIDTH-1:0] INIT_VALUE = '0,
  localparam int unsigned ADDR_W = $clog2(LUT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_req,
  output logic                 init_done,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [LUT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [LUT_WIDTH-1:0] resp_rdata,
  output logic                 lut_wr_en,
  output logic [ADDR_W-1:0]    lut_wr_addr,
  output logic [LUT_WIDTH-1:0] lut_wr_data,
  output logic [ADDR_W-1:0]    lut_rd_addr,
  input  logic [LUT_WIDTH-1:0] lut_rd_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LUT_DEPTH - 1);

  lut_ctrl_state_e   state;
  logic [ADDR_W-1:0] cnt;

  logic run_ready;
  logic req_acc;
  logic wr_acc;
  logic rd_acc;

  // clear_req wins over a same-cycle request; a held response blocks new ones.
  assign run_ready = (state == RUN) & ~clear_req & (~resp_valid | resp_ready);
  assign req_acc   = req_valid & run_ready;
  assign wr_acc    = req_acc & req_we;
  assign rd_acc    = req_acc & ~req_we;

  assign req_ready = run_ready;
  assign init_done = (state == RUN);

  // Write port and read address: the sweep owns the write port in INIT,
  // accepted writes pass straight through in RUN.
  always_comb begin
    lut_wr_en   = 1'b0;
    lut_wr_addr = '0;
    lut_wr_data = '0;
    lut_rd_addr = '0;
    case (state)
      INIT: begin
        lut_wr_en   = 1'b1;
        lut_wr_addr = cnt;
        lut_wr_data = INIT_VALUE;
      end
      RUN: begin
        lut_rd_addr = req_addr;
        if (wr_acc) begin
          lut_wr_en   = 1'b1;
          lut_wr_addr = req_addr;
          lut_wr_data = req_wdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RST;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        RST: begin
          state <= INIT;
          cnt   <= '0;
        end
        INIT: begin
          if (cnt == LAST_ADDR) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (clear_req) begin
            state <= INIT;
            cnt   <= '0;
          end
        end
        default: state <= RST;
      endcase

      // A pending response survives a clear and drains during INIT.
      if (rd_acc) begin
        resp_valid <= 1'b1;
        resp_rdata <= lut_rd_data;
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule
